// File: rtl/dual_port_memory.sv
// Dual-port synchronous RAM: port A read/write with byte enables, port B read-only,
// selectable read-during-write behaviour, and a clear sequencer that fills the array.
module dual_port_memory #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_SPACE     = 14,
  parameter int                    BYTE_WIDTH     = 8,
  parameter bit                    RDW_NEW        = 1'b0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  localparam int                   NB             = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [NB-1:0]         a_be,
  input  logic [ADDR_SPACE-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic [DATA_WIDTH-1:0] a_out,
  input  logic                  b_en,
  input  logic [ADDR_SPACE-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_out,
  input  logic                  clr,
  output logic                  busy
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                  state, state_next;
  logic [ADDR_SPACE-1:0]   ptr, ptr_next;
  logic [DATA_WIDTH-1:0]   mem [0:(1<<ADDR_SPACE)-1];

  logic                    wr_en;
  logic [ADDR_SPACE-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [NB-1:0]           wr_be;
  logic                    a_rd, b_rd, a_wr;
  logic [DATA_WIDTH-1:0]   a_old, b_old, a_merged;

  // busy is a direct decode of the state register, so it doubles as the FSM debug view.
  assign busy  = (state == CLEAR);
  assign a_old = mem[a_addr];
  assign b_old = mem[b_addr];
  assign a_wr  = wr_en && !busy;

  always_comb begin
    a_merged = a_old;
    for (int i = 0; i < NB; i++) begin
      if (a_be[i]) a_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = a_data[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    wr_en      = 1'b0;
    wr_addr    = a_addr;
    wr_data    = a_data;
    wr_be      = a_be;
    a_rd       = 1'b0;
    b_rd       = 1'b0;
    case (state)
      IDLE: begin
        a_rd = a_en;
        b_rd = b_en;
        // A clear request wins over a same-cycle port A write.
        if (clr) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end else if (a_en && a_we) begin
          wr_en = 1'b1;
        end
      end
      CLEAR: begin
        wr_en    = 1'b1;
        wr_addr  = ptr;
        wr_data  = CLEAR_VALUE;
        wr_be    = '1;
        ptr_next = ptr + 1'b1;
        if (ptr == '1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst) wr_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? CLEAR : IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Port B sees the merged word only when A writes the very address B reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
    end else begin
      if (a_rd) a_out <= (RDW_NEW && a_wr) ? a_merged : a_old;
      if (b_rd) b_out <= (RDW_NEW && a_wr && (b_addr == a_addr)) ? a_merged : b_old;
    end
  end

endmodule
